// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional alignment checking is enabled by defining IF_ALIGN_CHECK_EN.
package if_fetch_pkg;

  typedef logic [5:0]  Stall_t;
  typedef logic        Bit_t;
  typedef logic [31:0] Inst_addr_t;
  typedef logic [31:0] Inst_t;

  localparam Inst_addr_t  PC_RESET_ADDR = 32'hBFC0_0000;
  localparam Inst_t       ZERO_WORD     = 32'h0000_0000;
  localparam int unsigned STALL_IF      = 1;
  localparam Inst_addr_t  PC_INC        = 32'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } Fetch_state_t;

  // True when an instruction address is not word aligned.
  function automatic Bit_t is_misaligned(input Inst_addr_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_pc_sel.sv
// Next-PC priority mux: exception redirect, then pending branch, then pc + 4.
module if_pc_sel
  import if_fetch_pkg::*;
(
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic [31:0] pc,
  output logic [31:0] next_pc
);

  // Redirect priority; pc + 4 wraps naturally at 2^32.
  always_comb begin
    if (flush) begin
      next_pc = flush_pc;
    end else if (br_valid) begin
      next_pc = br_target;
    end else begin
      next_pc = pc + PC_INC;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus and presents one
// instruction per cycle to IF/ID. Branches honour the delay slot; flushes redirect at once
// or, with a request already outstanding, after that request drains.
// Define IF_ALIGN_CHECK_EN to add if_excp and suppress fetches from misaligned PCs.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        if_excp
`endif
);

  Fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  hold_inst;
  logic [31:0]  br_tgt;
  logic [31:0]  redir_pc;
  logic         br_pend;

  logic         in_req;
  logic         fetch_done;
  logic         valid;
  logic         consume;
  logic         br_valid;
  logic [31:0]  br_target_eff;
  logic [31:0]  fetch_inst;
  logic [31:0]  next_pc;

  // Only the IF bit of the stall vector matters here.
  logic         unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign in_req = (state == REQ);

`ifdef IF_ALIGN_CHECK_EN
  logic bad_addr;
  logic hold_excp;

  // A misaligned PC completes locally without touching the bus.
  assign bad_addr   = in_req && is_misaligned(pc);
  assign fetch_done = in_req && (ibus_ack || bad_addr);
  assign fetch_inst = bad_addr ? ZERO_WORD : ibus_rdata;
  assign ibus_req   = (in_req && !bad_addr) || (state == DISCARD);
  assign if_excp    = valid && ((state == HOLD) ? hold_excp : bad_addr);
`else
  assign fetch_done = in_req && ibus_ack;
  assign fetch_inst = ibus_rdata;
  assign ibus_req   = in_req || (state == DISCARD);
`endif

  // An instruction is presented when one is in hand and no redirect is happening.
  assign valid       = !flush && ((state == HOLD) || fetch_done);
  assign consume     = valid && !stall[STALL_IF];
  assign stallreq_if = !valid;

  // A branch arriving in the same cycle as its delay slot is consumed takes effect at once.
  assign br_valid      = br_pend || branch_flag;
  assign br_target_eff = branch_flag ? branch_target : br_tgt;

  // The address only moves on consumption or redirect, so it is stable while req is high.
  assign ibus_addr = pc;
  assign if_pc     = pc;

  // Instruction presented to IF/ID; zero whenever nothing valid is available.
  always_comb begin
    if_inst = ZERO_WORD;
    if (valid) begin
      if_inst = (state == HOLD) ? hold_inst : fetch_inst;
    end
  end

  if_pc_sel u_pc_sel (
    .flush     (flush),
    .flush_pc  (flush_pc),
    .br_valid  (br_valid),
    .br_target (br_target_eff),
    .pc        (pc),
    .next_pc   (next_pc)
  );

  // Fetch FSM with PC, hold buffer, branch and redirect bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= PC_RESET_ADDR;
      hold_inst <= ZERO_WORD;
      br_tgt    <= PC_RESET_ADDR;
      redir_pc  <= PC_RESET_ADDR;
      br_pend   <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      hold_excp <= 1'b0;
`endif
    end else begin
      if (flush || consume) begin
        br_pend <= 1'b0;
      end else if (branch_flag) begin
        br_pend <= 1'b1;
        br_tgt  <= branch_target;
      end

      case (state)
        IDLE: begin
          state <= REQ;
          if (flush) begin
            pc <= flush_pc;
          end
        end
        REQ: begin
          if (flush) begin
            if (fetch_done) begin
              pc <= next_pc;
            end else begin
              // The bus request cannot be withdrawn; let it drain first.
              redir_pc <= flush_pc;
              state    <= DISCARD;
            end
          end else if (fetch_done) begin
            if (consume) begin
              pc <= next_pc;
            end else begin
              hold_inst <= fetch_inst;
`ifdef IF_ALIGN_CHECK_EN
              hold_excp <= bad_addr;
`endif
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (flush || consume) begin
            pc    <= next_pc;
            state <= REQ;
          end
        end
        DISCARD: begin
          if (ibus_ack) begin
            pc    <= flush ? flush_pc : redir_pc;
            state <= REQ;
          end else if (flush) begin
            redir_pc <= flush_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus a randomized run checked
// against an architectural model of the expected instruction stream.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] R = PC_RESET_ADDR;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;
`ifdef IF_ALIGN_CHECK_EN
  logic        if_excp;
`endif

  int checks   = 0;
  int failures = 0;

  // Requested inputs for the next cycle
  logic        drv_stall, drv_flush, drv_br;
  logic [31:0] drv_fpc, drv_btgt;
  // Bus responder
  int          bus_wait;
  logic        bus_busy;
  int          bus_left;
  logic [31:0] sp_addr = 32'h0000_0001;
  logic [31:0] sp_data = 32'h0;
  // Sampled outputs
  logic        o_req, o_ack, o_stallreq, o_excp;
  logic [31:0] o_addr, o_pc, o_inst;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .ibus_req      (ibus_req),
    .ibus_addr     (ibus_addr),
    .ibus_ack      (ibus_ack),
    .ibus_rdata    (ibus_rdata),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq_if   (stallreq_if)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .if_excp       (if_excp)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents as seen by the bus
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == sp_addr) return sp_data;
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  // One clock: apply requested inputs, answer the bus, then sample outputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    stall         = drv_stall ? 6'b000010 : 6'b000000;
    flush         = drv_flush;
    flush_pc      = drv_fpc;
    branch_flag   = drv_br;
    branch_target = drv_btgt;
    if (ibus_req) begin
      if (!bus_busy) begin
        bus_busy = 1'b1;
        bus_left = (bus_wait < 0) ? int'($urandom_range(0, 3)) : bus_wait;
      end
      if (bus_left == 0) begin
        ibus_ack   = 1'b1;
        ibus_rdata = mem_word(ibus_addr);
        bus_busy   = 1'b0;
      end else begin
        ibus_ack   = 1'b0;
        ibus_rdata = $urandom;
        bus_left--;
      end
    end else begin
      ibus_ack   = 1'b0;
      ibus_rdata = $urandom;
    end
    #1;
    o_req      = ibus_req;
    o_addr     = ibus_addr;
    o_ack      = ibus_ack;
    o_stallreq = stallreq_if;
    o_pc       = if_pc;
    o_inst     = if_inst;
`ifdef IF_ALIGN_CHECK_EN
    o_excp     = if_excp;
`else
    o_excp     = 1'b0;
`endif
  endtask

  task automatic clear_drives();
    drv_stall = 1'b0; drv_flush = 1'b0; drv_br = 1'b0;
    drv_fpc = 32'h0; drv_btgt = 32'h0;
    stall = 6'b0; flush = 1'b0; flush_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0;
    ibus_ack = 1'b0; ibus_rdata = 32'h0;
    bus_busy = 1'b0; bus_left = 0;
  endtask

  // Reset for two edges; release just after an edge, leaving the DUT in its first cycle.
  task automatic do_reset();
    rst = 1'b0;
    clear_drives();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus_wait = 0;
    repeat (3) cycle();
    bus_wait = 3;
    repeat (2) cycle();
    // Asynchronous reset in the middle of an outstanding request
    rst = 1'b0;
    clear_drives();
    #1;
    checks++; if (ibus_req !== 1'b0) begin failures++;
      $display("FAIL reset_req got=%0h exp=0", ibus_req); end
    checks++; if (ibus_addr !== R) begin failures++;
      $display("FAIL reset_addr got=%h exp=%h", ibus_addr, R); end
    checks++; if (if_pc !== R) begin failures++;
      $display("FAIL reset_if_pc got=%h exp=%h", if_pc, R); end
    checks++; if (if_inst !== 32'h0) begin failures++;
      $display("FAIL reset_if_inst got=%h exp=0", if_inst); end
    checks++; if (stallreq_if !== 1'b1) begin failures++;
      $display("FAIL reset_stallreq got=%0h exp=1", stallreq_if); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (stallreq_if !== 1'b1 || ibus_req !== 1'b0) begin failures++;
      $display("FAIL idle_cycle got stallreq=%0h req=%0h exp stallreq=1 req=0",
               stallreq_if, ibus_req); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    bus_wait = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++; if (o_req !== 1'b1 || o_addr !== R + 32'(4 * i)) begin failures++;
        $display("FAIL stream_addr[%0d] got req=%0h addr=%h exp req=1 addr=%h",
                 i, o_req, o_addr, R + 32'(4 * i)); end
      checks++; if (o_stallreq !== 1'b0) begin failures++;
        $display("FAIL stream_stallreq[%0d] got=%0h exp=0", i, o_stallreq); end
      checks++; if (o_inst !== mem_word(R + 32'(4 * i)) || o_pc !== R + 32'(4 * i)) begin
        failures++;
        $display("FAIL stream_inst[%0d] got pc=%h inst=%h exp pc=%h inst=%h", i, o_pc,
                 o_inst, R + 32'(4 * i), mem_word(R + 32'(4 * i))); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    bus_wait = 3;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++; if (o_req !== 1'b1 || o_addr !== R) begin failures++;
        $display("FAIL wait_addr[%0d] got req=%0h addr=%h exp req=1 addr=%h",
                 i, o_req, o_addr, R); end
      checks++; if (o_stallreq !== (i < 3)) begin failures++;
        $display("FAIL wait_stallreq[%0d] got=%0h exp=%0h", i, o_stallreq, (i < 3)); end
    end
    checks++; if (o_inst !== mem_word(R)) begin failures++;
      $display("FAIL wait_inst got=%h exp=%h", o_inst, mem_word(R)); end
    cycle();
    checks++; if (o_addr !== R + 32'd4) begin failures++;
      $display("FAIL wait_next_addr got=%h exp=%h", o_addr, R + 32'd4); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    bus_wait = 0;
    sp_addr  = R + 32'd4;
    sp_data  = 32'h2400_0001;
    cycle();
    drv_stall = 1'b1;
    cycle();
    checks++; if (o_inst !== 32'h2400_0001 || o_pc !== R + 32'd4 || o_stallreq !== 1'b0) begin
      failures++;
      $display("FAIL hold_ack got pc=%h inst=%h stallreq=%0h exp pc=%h inst=24000001 stallreq=0",
               o_pc, o_inst, o_stallreq, R + 32'd4); end
    cycle();
    checks++; if (o_inst !== 32'h2400_0001 || o_req !== 1'b0 || o_stallreq !== 1'b0) begin
      failures++;
      $display("FAIL hold_stalled got inst=%h req=%0h stallreq=%0h exp inst=24000001 req=0 stallreq=0",
               o_inst, o_req, o_stallreq); end
    drv_stall = 1'b0;
    cycle();
    checks++; if (o_inst !== 32'h2400_0001 || o_stallreq !== 1'b0) begin failures++;
      $display("FAIL hold_release got inst=%h stallreq=%0h exp inst=24000001 stallreq=0",
               o_inst, o_stallreq); end
    cycle();
    checks++; if (o_req !== 1'b1 || o_addr !== R + 32'd8) begin failures++;
      $display("FAIL hold_next got req=%0h addr=%h exp req=1 addr=%h", o_req, o_addr,
               R + 32'd8); end
    sp_addr = 32'h0000_0001;
  endtask

  task automatic test_branch();
    do_reset();
    bus_wait = 0;
    repeat (2) cycle();
    drv_br   = 1'b1;
    drv_btgt = 32'h8000_0100;
    cycle();
    checks++; if (o_addr !== 32'hBFC0_0008 || o_stallreq !== 1'b0) begin failures++;
      $display("FAIL branch_slot got addr=%h stallreq=%0h exp addr=bfc00008 stallreq=0",
               o_addr, o_stallreq); end
    drv_br = 1'b0;
    cycle();
    checks++; if (o_addr !== 32'h8000_0100) begin failures++;
      $display("FAIL branch_target got=%h exp=80000100", o_addr); end
    cycle();
    checks++; if (o_addr !== 32'h8000_0104) begin failures++;
      $display("FAIL branch_after got=%h exp=80000104", o_addr); end
  endtask

  task automatic test_flush_discard();
    do_reset();
    bus_wait = 3;
    cycle();
    drv_flush = 1'b1;
    drv_fpc   = 32'h8000_0180;
    cycle();
    checks++; if (o_stallreq !== 1'b1 || o_addr !== R) begin failures++;
      $display("FAIL flush_cycle got stallreq=%0h addr=%h exp stallreq=1 addr=%h",
               o_stallreq, o_addr, R); end
    drv_flush = 1'b0;
    cycle();
    checks++; if (o_req !== 1'b1 || o_addr !== R || o_stallreq !== 1'b1) begin failures++;
      $display("FAIL discard_wait got req=%0h addr=%h stallreq=%0h exp req=1 addr=%h stallreq=1",
               o_req, o_addr, o_stallreq, R); end
    cycle();
    checks++; if (o_ack !== 1'b1 || o_stallreq !== 1'b1 || o_inst !== 32'h0) begin failures++;
      $display("FAIL discard_drop got ack=%0h stallreq=%0h inst=%h exp ack=1 stallreq=1 inst=0",
               o_ack, o_stallreq, o_inst); end
    cycle();
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h8000_0180) begin failures++;
      $display("FAIL discard_redirect got req=%0h addr=%h exp req=1 addr=80000180",
               o_req, o_addr); end
  endtask

  task automatic test_flush_hold();
    do_reset();
    bus_wait  = 0;
    cycle();
    drv_stall = 1'b1;
    cycle();
    drv_flush = 1'b1;
    drv_fpc   = 32'h8000_0200;
    cycle();
    checks++; if (o_stallreq !== 1'b1 || o_inst !== 32'h0) begin failures++;
      $display("FAIL flush_hold got stallreq=%0h inst=%h exp stallreq=1 inst=0",
               o_stallreq, o_inst); end
    drv_flush = 1'b0;
    drv_stall = 1'b0;
    cycle();
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h8000_0200) begin failures++;
      $display("FAIL flush_hold_next got req=%0h addr=%h exp req=1 addr=80000200",
               o_req, o_addr); end
  endtask

`ifdef IF_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset();
    bus_wait = 0;
    repeat (2) cycle();
    drv_br   = 1'b1;
    drv_btgt = 32'h8000_0102;
    cycle();
    checks++; if (o_excp !== 1'b0) begin failures++;
      $display("FAIL align_slot_excp got=%0h exp=0", o_excp); end
    drv_br = 1'b0;
    cycle();
    checks++; if (o_req !== 1'b0 || o_excp !== 1'b1 || o_inst !== 32'h0 ||
                  o_stallreq !== 1'b0 || o_pc !== 32'h8000_0102) begin failures++;
      $display("FAIL align_excp got req=%0h excp=%0h inst=%h stallreq=%0h pc=%h exp 0 1 0 0 80000102",
               o_req, o_excp, o_inst, o_stallreq, o_pc); end
  endtask
`endif

  // Randomized run against the architectural stream: each consumed instruction must be the
  // next one in program order, with delayed branches and immediate exception redirects.
  task automatic test_random();
    logic [31:0] exp_pc, m_tgt, out_addr, tmp;
    logic        m_pend, out_busy;
    int          idle;
    do_reset();
    bus_wait = -1;
    exp_pc = R; m_pend = 1'b0; m_tgt = 32'h0; out_busy = 1'b0; out_addr = 32'h0; idle = 0;
    for (int n = 0; n < 1500; n++) begin
      drv_stall = ($urandom_range(0, 3) == 0);
      drv_flush = ($urandom_range(0, 29) == 0);
      tmp       = $urandom;
      drv_fpc   = {tmp[31:2], 2'b00};
      drv_br    = !drv_flush && ($urandom_range(0, 9) == 0);
      tmp       = $urandom;
      drv_btgt  = {tmp[31:2], 2'b00};
      cycle();
      if (out_busy) begin
        checks++; if (o_req !== 1'b1 || o_addr !== out_addr) begin failures++;
          $display("FAIL rnd_bus_stable[%0d] got req=%0h addr=%h exp req=1 addr=%h",
                   n, o_req, o_addr, out_addr); end
      end
      out_busy = o_req && !o_ack;
      out_addr = o_addr;
      if (drv_flush) begin
        checks++; if (o_stallreq !== 1'b1) begin failures++;
          $display("FAIL rnd_flush_stallreq[%0d] got=%0h exp=1", n, o_stallreq); end
        exp_pc = drv_fpc;
        m_pend = 1'b0;
        idle   = 0;
      end else if (!o_stallreq) begin
        checks++; if (o_pc !== exp_pc || o_inst !== mem_word(exp_pc)) begin failures++;
          $display("FAIL rnd_inst[%0d] got pc=%h inst=%h exp pc=%h inst=%h", n, o_pc, o_inst,
                   exp_pc, mem_word(exp_pc)); end
        if (!drv_stall) begin
          exp_pc = drv_br ? drv_btgt : (m_pend ? m_tgt : exp_pc + 32'd4);
          m_pend = 1'b0;
          idle   = 0;
        end else if (drv_br) begin
          m_pend = 1'b1;
          m_tgt  = drv_btgt;
        end
      end else begin
        checks++; if (o_inst !== 32'h0) begin failures++;
          $display("FAIL rnd_bubble_inst[%0d] got=%h exp=0", n, o_inst); end
        if (drv_br) begin
          m_pend = 1'b1;
          m_tgt  = drv_btgt;
        end
        idle++;
      end
      if (idle > 40) begin
        failures++;
        $display("FAIL rnd_progress[%0d] got idle=%0d exp <=40", n, idle);
        break;
      end
    end
    clear_drives();
  endtask

  initial begin
    rst = 1'b0;
    bus_wait = 0;
    clear_drives();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_branch();
    test_flush_discard();
    test_flush_hold();
`ifdef IF_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
